// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one registered ALU core between two requesters.
// Optional grant statistics are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
   parameter int N       = 8,
   parameter int ALU_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic [3:0]   req0_s,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic [3:0]   req1_s,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_s,
   input  logic [N-1:0] alu_f,
   input  logic [5:0]   alu_flags,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic         resp_id,
   output logic [N-1:0] resp_f,
   output logic [5:0]   resp_flags,
   output logic [1:0]   dbg_state
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]  grant_cnt0,
   output logic [15:0]  grant_cnt1
`endif
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high. Requesters hold valid and operands stable until ready is seen;
   // the result stays on resp_* until resp_ready is seen with resp_valid.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] LAT4 = 4'(ALU_LAT);

   state_t     state;
   logic       last_grant;
   logic       cur_id;
   logic [3:0] cnt;
   logic       gnt0;
   logic       gnt1;

   // On contention the requester that did not win last time is served.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE) begin
         gnt0 = req0_valid && (!req1_valid || last_grant);
         gnt1 = req1_valid && (!req0_valid || !last_grant);
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign dbg_state  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cur_id     <= 1'b0;
         cnt        <= 4'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_s      <= 4'd0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_f     <= '0;
         resp_flags <= 6'd0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  alu_a      <= gnt1 ? req1_a : req0_a;
                  alu_b      <= gnt1 ? req1_b : req0_b;
                  alu_s      <= gnt1 ? req1_s : req0_s;
                  cur_id     <= gnt1;
                  last_grant <= gnt1;
                  cnt        <= LAT4;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               // cnt==0 means the core output has been valid for one full cycle.
               if (cnt == 4'd0) begin
                  resp_f     <= alu_f;
                  resp_flags <= alu_flags;
                  resp_id    <= cur_id;
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt0 <= 16'd0;
         grant_cnt1 <= 16'd0;
      end else begin
         if (gnt0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (gnt1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter at ALU_LAT=1 and ALU_LAT=3.
// Checks grant counters too when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;

   localparam int N = 8;
   localparam int LAT = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ALU_LAT=1 instance
   logic         req0_valid = 0, req1_valid = 0, resp_ready = 0;
   logic [N-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [3:0]   req0_s = 0, req1_s = 0;
   logic         req0_ready, req1_ready, resp_valid, resp_id;
   logic [N-1:0] alu_a, alu_b, alu_f, resp_f;
   logic [3:0]   alu_s;
   logic [5:0]   alu_flags, resp_flags;
   logic [1:0]   dbg_state;
   logic [13:0]  core1;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]  grant_cnt0, grant_cnt1;
`endif

   alu_share_arbiter #(.N(N), .ALU_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_f(alu_f), .alu_flags(alu_flags),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_f(resp_f), .resp_flags(resp_flags), .dbg_state(dbg_state)
`ifdef ALU_ARB_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
   );

   // ALU_LAT=3 instance
   logic         l3_r0v = 0, l3_r1v = 0, l3_rr = 0;
   logic [N-1:0] l3_r1a = 0, l3_r1b = 0;
   logic [3:0]   l3_r1s = 0;
   logic         l3_r0r, l3_r1r, l3_rv, l3_id;
   logic [N-1:0] l3_aa, l3_ab, l3_f, l3_rf;
   logic [3:0]   l3_as;
   logic [5:0]   l3_flags, l3_rflags;
   logic [1:0]   l3_state;
   logic [13:0]  c3_0, c3_1, c3_2;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]  l3_gc0, l3_gc1;
`endif

   alu_share_arbiter #(.N(N), .ALU_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst),
      .req0_valid(l3_r0v), .req0_ready(l3_r0r), .req0_a(8'h00), .req0_b(8'h00), .req0_s(4'h0),
      .req1_valid(l3_r1v), .req1_ready(l3_r1r), .req1_a(l3_r1a), .req1_b(l3_r1b), .req1_s(l3_r1s),
      .alu_a(l3_aa), .alu_b(l3_ab), .alu_s(l3_as), .alu_f(l3_f), .alu_flags(l3_flags),
      .resp_valid(l3_rv), .resp_ready(l3_rr), .resp_id(l3_id),
      .resp_f(l3_rf), .resp_flags(l3_rflags), .dbg_state(l3_state)
`ifdef ALU_ARB_STATS_EN
      , .grant_cnt0(l3_gc0), .grant_cnt1(l3_gc1)
`endif
   );

   // Reference ALU: returns {G,E,L,Zero,carryOut,Overflow, F}
   function automatic logic [13:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
      logic [8:0] w;
      logic       v;
      case (s[2:0])
         3'd0: w = {1'b0, a} + {1'b0, b};
         3'd1: w = {1'b0, a} - {1'b0, b};
         3'd2: w = {1'b0, a & b};
         3'd3: w = {1'b0, a | b};
         3'd4: w = {1'b0, a ^ b};
         3'd5: w = {1'b0, a};
         3'd6: w = {1'b0, b};
         default: w = {1'b0, ~a};
      endcase
      if (s[2:0] == 3'd0)      v = (a[7] == b[7]) && (w[7] != a[7]);
      else if (s[2:0] == 3'd1) v = (a[7] != b[7]) && (w[7] != a[7]);
      else                     v = 1'b0;
      return {($signed(a) > $signed(b)), (a == b), ($signed(a) < $signed(b)),
              (w[7:0] == 8'd0), w[8], v, w[7:0]};
   endfunction

   // Registered ALU core models with latency 1 and 3
   always_ff @(posedge clk) begin
      core1 <= alu_fn(alu_a, alu_b, alu_s);
      c3_0  <= alu_fn(l3_aa, l3_ab, l3_as);
      c3_1  <= c3_0;
      c3_2  <= c3_1;
   end
   assign {alu_flags, alu_f} = core1;
   assign {l3_flags, l3_f}   = c3_2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Transaction-level requester model: pending ops and round-robin pointer
   logic       pv [2];
   logic [7:0] pa [2];
   logic [7:0] pb [2];
   logic [3:0] ps [2];
   logic       last_m;
   int         gcnt_m [2];

   task automatic drive_bus;
      req0_valid = pv[0];
      req0_a = pv[0] ? pa[0] : 8'($urandom);
      req0_b = pv[0] ? pb[0] : 8'($urandom);
      req0_s = pv[0] ? ps[0] : 4'($urandom);
      req1_valid = pv[1];
      req1_a = pv[1] ? pa[1] : 8'($urandom);
      req1_b = pv[1] ? pb[1] : 8'($urandom);
      req1_s = pv[1] ? ps[1] : 4'($urandom);
   endtask

   task automatic new_req(input int r);
      if (!pv[r]) begin
         pv[r] = 1'b1;
         pa[r] = 8'($urandom);
         pb[r] = 8'($urandom);
         ps[r] = 4'($urandom_range(0, 15));
      end
   endtask

   // One arbitration round from IDLE through the response handshake
   task automatic do_op(input bit n0, input bit n1, input int wait_cycles);
      int          win;
      logic [7:0]  ea, eb;
      logic [3:0]  es;
      logic [13:0] exp;
      logic [21:0] held;
      if (n0) new_req(0);
      if (n1) new_req(1);
      drive_bus();
      #1;
      if (!pv[0] && !pv[1]) begin
         check("idle_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
         step();
         check("idle_state", {30'd0, dbg_state}, 32'd0);
         return;
      end
      win = (pv[0] && pv[1]) ? int'(!last_m) : (pv[0] ? 0 : 1);
      last_m = win[0];
      gcnt_m[win]++;
      check("grant", {30'd0, req1_ready, req0_ready}, (win == 0) ? 32'd1 : 32'd2);
      ea = pa[win]; eb = pb[win]; es = ps[win];
      exp = alu_fn(ea, eb, es);
      pv[win] = 1'b0;
      step();
      for (int j = 0; j <= LAT; j++) begin
         drive_bus();
         #1;
         check("issue", {13'd0, alu_a, alu_b, alu_s, req0_ready, req1_ready, resp_valid},
               {13'd0, ea, eb, es, 3'b000});
         step();
      end
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_id", {31'd0, resp_id}, win);
      check("resp_f", {24'd0, resp_f}, {24'd0, exp[7:0]});
      check("resp_flags", {26'd0, resp_flags}, {26'd0, exp[13:8]});
      held = {resp_valid, resp_id, resp_f, resp_flags, req0_ready, req1_ready};
      for (int j = 0; j < wait_cycles; j++) begin
         drive_bus();
         step();
         check("backpressure", {10'd0, resp_valid, resp_id, resp_f, resp_flags, req0_ready, req1_ready},
               {10'd0, held});
      end
      resp_ready = 1'b1;
      #1;
      check("done_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      step();
      resp_ready = 1'b0;
      check("handshake", {29'd0, resp_valid, dbg_state}, 32'd0);
   endtask

   task automatic check_stats;
`ifdef ALU_ARB_STATS_EN
      check("grant_cnt0", {16'd0, grant_cnt0}, gcnt_m[0]);
      check("grant_cnt1", {16'd0, grant_cnt1}, gcnt_m[1]);
`endif
   endtask

   initial begin
      logic [13:0] e3;
      pv[0] = 0; pv[1] = 0; pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0; ps[0] = 0; ps[1] = 0;
      last_m = 1'b1;
      gcnt_m[0] = 0; gcnt_m[1] = 0;

      // Reset values
      rst = 1'b1;
      repeat (2) step();
      check("rst_outs", {4'd0, req0_ready, req1_ready, alu_a, alu_b, alu_s, resp_valid, resp_id, dbg_state},
            32'd0);
      check("rst_resp", {18'd0, resp_f, resp_flags}, 32'd0);
      check("rst_lat3", {l3_r0r, l3_r1r, l3_rv, l3_id, l3_aa, l3_ab, l3_rf}, 32'd0);
      check_stats();
      rst = 1'b0;
      step();

      // Single op: 5 + 3 from requester 0
      pv[0] = 1; pa[0] = 8'sd5; pb[0] = 8'sd3; ps[0] = 4'b0000;
      do_op(0, 0, 0);
      check("single_f", {24'd0, resp_f}, 32'd8);

      // Contention: both valid continuously, grants alternate
      for (int i = 0; i < 4; i++) do_op(1, 1, 0);
      // Backpressure with the other requester waiting
      do_op(1, 1, 5);
      // Randomized traffic
      for (int i = 0; i < 24; i++)
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      check_stats();

      // Reset in the middle of an operation
      new_req(0);
      drive_bus();
      #1;
      if (pv[1]) check("mid_grant", {30'd0, req1_ready, req0_ready}, last_m ? 32'd1 : 32'd2);
      step();
      rst = 1'b1;
      pv[0] = 0; pv[1] = 0;
      drive_bus();
      step();
      check("midrst_outs", {4'd0, req0_ready, req1_ready, alu_a, alu_b, alu_s, resp_valid, resp_id, dbg_state},
            32'd0);
      check("midrst_resp", {18'd0, resp_f, resp_flags}, 32'd0);
      last_m = 1'b1;
      gcnt_m[0] = 0; gcnt_m[1] = 0;
      check_stats();
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step();
         check("midrst_noresp", {31'd0, resp_valid}, 32'd0);
      end
      do_op(0, 1, 0);
      do_op(1, 1, 1);
      do_op(1, 1, 0);
      check_stats();

      // ALU_LAT=3: req1 -128 op -1
      l3_r1v = 1'b1; l3_r1a = 8'h80; l3_r1b = 8'hFF; l3_r1s = 4'($urandom_range(0, 7));
      e3 = alu_fn(8'h80, 8'hFF, l3_r1s);
      #1;
      check("l3_grant", {30'd0, l3_r1r, l3_r0r}, 32'd2);
      step();
      l3_r1v = 1'b0; l3_r1a = 8'($urandom); l3_r1b = 8'($urandom);
      for (int j = 0; j <= 3; j++) begin
         check("l3_issue", {15'd0, l3_aa, l3_ab, l3_rv}, {15'd0, 8'h80, 8'hFF, 1'b0});
         step();
      end
      check("l3_resp", {16'd0, l3_rv, l3_id, l3_flags[5:0] & 6'd0, l3_rf}, {16'd0, 2'b11, 6'd0, e3[7:0]});
      check("l3_flags", {26'd0, l3_rflags}, {26'd0, e3[13:8]});
      l3_rr = 1'b1;
      step();
      l3_rr = 1'b0;
      check("l3_handshake", {29'd0, l3_rv, l3_state}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
